// File: rtl/odd_even_stream_gen.sv
// Clocked odd/even sequence source: emits COUNT consecutive same-parity values
// as a valid/ready stream, with busy and a one-cycle done pulse.
module odd_even_stream_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             is_even_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] value_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      value_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            state_d     = RUN;
            // Seed's low bit is replaced so the sequence has the requested parity.
            value_d     = (seed_i & ~WIDTH'(1)) | {{(WIDTH-1){1'b0}}, ~is_even_i};
            remaining_d = count_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (ready_i) begin
          if (remaining_q > CNT_W'(1)) begin
            value_d     = value_q + WIDTH'(2);
            remaining_d = remaining_q - CNT_W'(1);
          end else begin
            state_d     = DONE;
            remaining_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign value_o = value_q;
  assign valid_o = (state_q == RUN);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule
